booth_divider: RTL and testbench
================================

BOOTH_DIVIDER -- requirements
Module: booth_divider

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 16, meaning the width of the dividend, divisor, quotient and remainder.
REQ-002 SHALL have parameter WIDTH_REM, default 17, meaning the width of the internal partial-remainder register (WIDTH_IN+1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_a, input, WIDTH_IN bits: signed two's-complement dividend.
REQ-006 SHALL have port in_b, input, WIDTH_IN bits: signed two's-complement divisor.
REQ-007 SHALL have port valid_in, input, 1 bit: operands valid; sampled only in IDLE.
REQ-008 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 SHALL have port valid_out, output, 1 bit: one-cycle pulse marking valid results.
REQ-010 SHALL have port quotient, output, WIDTH_IN bits: signed quotient.
REQ-011 SHALL have port remainder, output, WIDTH_IN bits: signed remainder.
REQ-012 SHALL have port div_by_zero, output, 1 bit: the divisor was zero; valid together with valid_out.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-014 In IDLE with valid_in=1: SHALL register |in_a| and |in_b|, the operand signs and the zero-divisor flag, clear the iteration counter, and go to CALC.
REQ-015 In IDLE with valid_in=0: SHALL remain in IDLE.
REQ-016 CALC SHALL run exactly WIDTH_IN cycles of unsigned restoring division, one quotient bit per cycle, MSB first.
- Each cycle: shift {partial remainder, dividend} left by 1.
- Trial subtract the divisor magnitude in WIDTH_REM bits.
- If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
REQ-017 After the WIDTH_IN-th CALC cycle the FSM SHALL go to FIX.
- FIX negates the quotient if the operand signs differ.
- FIX negates the remainder if the dividend was negative (truncation toward zero; remainder takes the dividend's sign).
REQ-018 FIX SHALL go to DONE; DONE SHALL drive valid_out=1 for exactly one cycle and then return to IDLE.
REQ-019 Latency SHALL be fixed: valid_in accepted at edge N gives valid_out high in the cycle following edge N+WIDTH_IN+2 (18 cycles at the default width), for every operand value.
REQ-020 valid_in asserted while busy=1 (including the DONE cycle) SHALL be ignored; there is no queuing.
REQ-021 quotient, remainder and div_by_zero SHALL update only on entry to DONE and hold until the next DONE.
REQ-022 Divisor zero: the normal sequence and latency SHALL still run; results SHALL be quotient = all ones, remainder = in_a, div_by_zero = 1.
REQ-023 Overflow case (most-negative dividend / -1): quotient SHALL be the most-negative value (wrap), remainder 0, div_by_zero 0.
REQ-024 Magnitude of the most-negative operand SHALL be taken as the unsigned value 2^(WIDTH_IN-1) without error.

Reset
REQ-025 reset=1 SHALL force state to IDLE and clear the counter and all datapath registers.
REQ-026 reset=1 SHALL force busy=0, valid_out=0, quotient=0, remainder=0 and div_by_zero=0 at the next edge.
REQ-027 Reset asserted mid-operation SHALL abort it; no valid_out SHALL be produced for the aborted operation.
REQ-028 reset SHALL take priority over valid_in in the same cycle.

Structure
REQ-029 A shared package booth_div_pkg SHALL hold the state enum typedef, the default widths and the counter width constant ($clog2(WIDTH_IN+1)).
REQ-030 The FSM SHALL be the sub-module div_controller, which outputs load, shift and fix enables plus valid_out.
REQ-031 The shift/subtract/sign-fix registers SHALL be in booth_divider.

Verification
REQ-032 in_a=100, in_b=7, valid_in for one cycle: valid_out exactly 18 cycles later with quotient=14, remainder=2, div_by_zero=0.
REQ-033 in_a=-100 (0xFF9C), in_b=7: quotient=0xFFF2 (-14), remainder=0xFFFE (-2).
REQ-034 in_a=5, in_b=0: valid_out after 18 cycles with quotient=0xFFFF, remainder=0x0005, div_by_zero=1.
REQ-035 in_a=0x8000, in_b=0xFFFF: quotient=0x8000, remainder=0; separately, in_a=0x8000, in_b=2: quotient=0xC000, remainder=0.
REQ-036 Accept 100/7, then drive valid_in with 9/3 on cycles 3 and 17 (DONE cycle): only one valid_out, result 14/2. Then 9/3 issued in IDLE gives 3/0.
REQ-037 Accept 100/7 and assert reset at cycle 8: busy=0 next cycle, outputs zero, no valid_out within 30 cycles.

Source files
------------

// File: rtl/booth_div_pkg.sv
// Shared definitions for the signed sequential divider.
//   - default operand / partial-remainder widths
//   - iteration counter width
//   - controller state encoding
package booth_div_pkg;

  localparam int DEF_WIDTH_IN  = 16;
  localparam int DEF_WIDTH_REM = DEF_WIDTH_IN + 1;
  localparam int DEF_CNT_W     = $clog2(DEF_WIDTH_IN + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_controller.sv
// Sequencing FSM for the signed divider.
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   valid_in_i   operand strobe, only honoured in IDLE
//   load_o       capture operands this cycle (IDLE and valid_in_i)
//   shift_o      perform one restoring-division step this cycle
//   fix_o        apply sign correction and publish results this cycle
//   busy_o       high in every state except IDLE
//   valid_out_o  one-cycle pulse, registered out of DONE
module div_controller
  import booth_div_pkg::*;
#(
  parameter int WIDTH_IN = DEF_WIDTH_IN,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_in_i,
  output logic load_o,
  output logic shift_o,
  output logic fix_o,
  output logic busy_o,
  output logic valid_out_o
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH_IN - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             shift_q;
  logic             fix_q;
  logic             busy_q;
  logic             valid_q;

  // Operand capture must happen on the accepting edge, so load is decoded
  // directly from the current state rather than registered.
  assign load_o      = (state_q == IDLE) && valid_in_i;
  assign shift_o     = shift_q;
  assign fix_o       = fix_q;
  assign busy_o      = busy_q;
  assign valid_out_o = valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= 1'b0;
      fix_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in_i) begin
            state_q <= CALC;
            cnt_q   <= '0;
            shift_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          if (cnt_q == LAST_STEP) begin
            state_q <= FIX;
            shift_q <= 1'b0;
            fix_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        FIX: begin
          state_q <= DONE;
          fix_q   <= 1'b0;
        end
        DONE: begin
          // busy drops and the result strobe rises together on leaving DONE
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/booth_divider.sv
// Signed sequential divider: magnitude restoring division, one quotient bit
// per clock MSB first, followed by a sign-correction step. Quotient
// truncates toward zero; remainder carries the dividend's sign.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   in_a, in_b         signed dividend / divisor, sampled when accepted
//   valid_in           operand strobe (ignored while busy)
//   busy               operation in progress
//   valid_out          one-cycle result strobe
//   quotient, remainder, div_by_zero   held results of the last operation
module booth_divider
  import booth_div_pkg::*;
#(
  parameter int WIDTH_IN  = DEF_WIDTH_IN,
  parameter int WIDTH_REM = DEF_WIDTH_REM
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [WIDTH_IN-1:0] in_a,
  input  logic signed [WIDTH_IN-1:0] in_b,
  input  logic                       valid_in,
  output logic                       busy,
  output logic                       valid_out,
  output logic signed [WIDTH_IN-1:0] quotient,
  output logic signed [WIDTH_IN-1:0] remainder,
  output logic                       div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH_IN + 1);

  logic load, shift, fix;

  div_controller #(
    .WIDTH_IN (WIDTH_IN),
    .CNT_W    (CNT_W)
  ) u_ctrl (
    .clk_i       (clk),
    .rst_i       (reset),
    .valid_in_i  (valid_in),
    .load_o      (load),
    .shift_o     (shift),
    .fix_o       (fix),
    .busy_o      (busy),
    .valid_out_o (valid_out)
  );

  // Two's-complement magnitude; the most-negative value maps to 2^(W-1).
  function automatic logic [WIDTH_IN-1:0] magnitude(input logic [WIDTH_IN-1:0] v);
    return v[WIDTH_IN-1] ? -v : v;
  endfunction

  logic [WIDTH_REM-1:0] prem_q, prem_d;    // partial remainder
  logic [WIDTH_IN-1:0]  dvd_q, dvd_d;      // dividend bits in, quotient bits out
  logic [WIDTH_IN-1:0]  dvs_q;             // divisor magnitude
  logic                 neg_quot_q;        // operand signs differ
  logic                 neg_rem_q;         // dividend negative
  logic                 dz_q;              // divisor was zero
  logic [WIDTH_IN-1:0]  quot_q, rem_q;
  logic                 dz_out_q;

  logic [WIDTH_REM-1:0] shifted_rem, trial_rem;
  logic                 q_bit;
  logic [WIDTH_IN-1:0]  quot_fix, rem_fix;
  logic                 prem_msb_unused;

  // The partial remainder never exceeds twice the divisor magnitude, so its
  // top bit only matters as the sign of the trial subtraction.
  assign prem_msb_unused = prem_q[WIDTH_REM-1];

  always_comb begin
    shifted_rem = {prem_q[WIDTH_REM-2:0], dvd_q[WIDTH_IN-1]};
    trial_rem   = shifted_rem - {{(WIDTH_REM-WIDTH_IN){1'b0}}, dvs_q};
    q_bit       = ~trial_rem[WIDTH_REM-1];
    prem_d      = q_bit ? trial_rem : shifted_rem;
    dvd_d       = {dvd_q[WIDTH_IN-2:0], q_bit};
    // With a zero divisor every trial succeeds, so the remainder register
    // ends up holding |in_a| and the sign fix restores in_a exactly.
    quot_fix    = dz_q ? '1 : (neg_quot_q ? -dvd_q : dvd_q);
    rem_fix     = neg_rem_q ? -prem_q[WIDTH_IN-1:0] : prem_q[WIDTH_IN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prem_q     <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dz_out_q   <= 1'b0;
    end else begin
      if (load) begin
        prem_q     <= '0;
        dvd_q      <= magnitude(in_a);
        dvs_q      <= magnitude(in_b);
        neg_quot_q <= in_a[WIDTH_IN-1] ^ in_b[WIDTH_IN-1];
        neg_rem_q  <= in_a[WIDTH_IN-1];
        dz_q       <= (in_b == '0);
      end else if (shift) begin
        prem_q <= prem_d;
        dvd_q  <= dvd_d;
      end
      if (fix) begin
        quot_q   <= quot_fix;
        rem_q    <= rem_fix;
        dz_out_q <= dz_q;
      end
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_out_q;

endmodule

// File: tb/tb_booth_divider.sv
// Bench for booth_divider: a cycle-level reference model (integer division
// plus a busy countdown) compared against the DUT every cycle, with directed
// operations carrying hand-computed literal results.
module tb_booth_divider;

  localparam int W = 16;
  localparam int LAT = 18;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_a, in_b;
  logic         valid_in;
  logic         busy, valid_out, div_by_zero;
  logic [W-1:0] quotient, remainder;

  booth_divider #(.WIDTH_IN(W), .WIDTH_REM(W + 1)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_a        (in_a),
    .in_b        (in_b),
    .valid_in    (valid_in),
    .busy        (busy),
    .valid_out   (valid_out),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Signed division rules: truncate toward zero, remainder follows dividend,
  // zero divisor gives all-ones / dividend, overflow wraps in 16 bits.
  function automatic logic [W-1:0] exp_quot(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ib == 0) return '1;
    return W'(ia / ib);
  endfunction

  function automatic logic [W-1:0] exp_rem(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (ib == 0) return a;
    return W'(ia % ib);
  endfunction

  // Reference model: an accepted operation keeps the unit busy for LAT
  // cycles; results appear one cycle before the valid_out strobe.
  int           m_cnt = 0;
  bit           m_idle_pre;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic         m_dz = 1'b0, p_dz = 1'b0, m_vo = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0;
      m_q   = '0;
      m_r   = '0;
      m_dz  = 1'b0;
      m_vo  = 1'b0;
    end else begin
      m_idle_pre = (m_cnt == 0);
      m_vo = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 1) begin
          m_q  = p_q;
          m_r  = p_r;
          m_dz = p_dz;
        end else if (m_cnt == 0) begin
          m_vo = 1'b1;
        end
      end
      if (m_idle_pre && valid_in) begin
        m_cnt = LAT;
        p_q   = exp_quot(in_a, in_b);
        p_r   = exp_rem(in_a, in_b);
        p_dz  = (in_b == '0);
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model busy", busy, m_cnt > 0);
      chk("model valid_out", valid_out, m_vo);
      chk("model quotient", quotient, m_q);
      chk("model remainder", remainder, m_r);
      chk("model div_by_zero", div_by_zero, m_dz);
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input string nm);
    int lat;
    @(negedge clk);
    in_a = a;
    in_b = b;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid_out && lat < 40);
    chk({nm, " latency"}, lat, LAT);
    chk({nm, " quotient"}, quotient, eq);
    chk({nm, " remainder"}, remainder, er);
    chk({nm, " div_by_zero"}, div_by_zero, edz);
  endtask

  initial begin
    int pulses;
    reset    = 1'b1;
    valid_in = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset valid_out", valid_out, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    reset = 1'b0;
    check_en = 1'b1;

    run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, "100/7");
    run_op(16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0, "-100/7");
    run_op(16'hFFF9, 16'hFFFE, 16'd3, 16'hFFFF, 1'b0, "-7/-2");
    run_op(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, "7/-2");
    run_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, "5/0");

    // Abort mid-calculation: outputs from 5/0 must be wiped, no strobe follows.
    @(negedge clk);
    in_a = 16'd100;
    in_b = 16'd7;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    for (int k = 1; k <= 8; k++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort valid_out", valid_out, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort div_by_zero", div_by_zero, 0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (valid_out) pulses++;
    end
    chk("abort no valid_out", pulses, 0);

    run_op(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, "min/-1");
    run_op(16'h8000, 16'd2, 16'hC000, 16'd0, 1'b0, "min/2");
    run_op(16'h8000, 16'h8000, 16'd1, 16'd0, 1'b0, "min/min");

    // Operands offered during CALC and during DONE must be dropped.
    @(negedge clk);
    in_a = 16'd100;
    in_b = 16'd7;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (valid_out) begin
        pulses++;
        if (pulses == 1) begin
          chk("busy-drop latency", k, LAT);
          chk("busy-drop quotient", quotient, 16'd14);
          chk("busy-drop remainder", remainder, 16'd2);
        end
      end
      if (k == 3 || k == 17) begin
        in_a = 16'd9;
        in_b = 16'd3;
        valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
    end
    chk("busy-drop pulses", pulses, 1);
    run_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, "9/3");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
